// File: rtl/cfg.sv
// Shared configuration for the decode stage: data widths, RV32I opcodes and
// the control-field encodings that the execute/memory/writeback path consumes.
package cfg;

  localparam int INST_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [INST_WIDTH-1:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_FOUR   = 32'd4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_SLT  = 4'd8,  ALU_SLTU = 4'd9,  ALU_EQ  = 4'd10, ALU_NE  = 4'd11,
    ALU_LT   = 4'd12, ALU_GE   = 4'd13, ALU_LTU = 4'd14, ALU_GEU = 4'd15
  } alu_type_e;

  typedef enum logic [1:0] {
    ALU_A_RS1 = 2'd0, ALU_A_PC = 2'd1, ALU_A_ZERO = 2'd2
  } alu_a_e;

  typedef enum logic [1:0] {
    ALU_B_RS2 = 2'd0, ALU_B_IMM = 2'd1, ALU_B_FOUR = 2'd2
  } alu_b_e;

  typedef enum logic [3:0] {
    JMP_NONE = 4'd0, JMP_JAL = 4'd1, JMP_JALR = 4'd2, JMP_BEQ  = 4'd3,
    JMP_BNE  = 4'd4, JMP_BLT = 4'd5, JMP_BGE  = 4'd6, JMP_BLTU = 4'd7,
    JMP_BGEU = 4'd8
  } jmp_type_e;

  // {unsigned, size}: this matches the load/store funct3 field bit for bit
  typedef enum logic [2:0] {
    BYT_B = 3'b000, BYT_H = 3'b001, BYT_W = 3'b010, BYT_BU = 3'b100, BYT_HU = 3'b101
  } ram_byt_e;

  typedef enum logic [1:0] {
    WR_SRC_ALU = 2'd0, WR_SRC_MEM = 2'd1, WR_SRC_PC4 = 2'd2
  } wr_src_e;

  // Loads encode LB/LH/LW/LBU/LHU; funct3 011, 110 and 111 are not loads.
  function automatic logic is_load_funct3(input logic [2:0] f3);
    return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
  endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate generator: builds the five RV32I immediate formats and picks the
// one belonging to the current opcode. Opcodes without an immediate give 0.
import cfg::*;

module idu_imm_gen (
  input  logic [INST_WIDTH-1:0] i_inst,
  output logic [DATA_WIDTH-1:0] o_imm
);

  logic [DATA_WIDTH-1:0] w_imm_i;
  logic [DATA_WIDTH-1:0] w_imm_s;
  logic [DATA_WIDTH-1:0] w_imm_b;
  logic [DATA_WIDTH-1:0] w_imm_u;
  logic [DATA_WIDTH-1:0] w_imm_j;

  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'd0};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // Format select by opcode; FENCE/SYSTEM/unknown yield zero so a NOP carries no data.
  always_comb begin
    o_imm = DATA_ZERO;
    case (i_inst[6:0])
      OPC_JALR, OPC_LOAD, OPC_OPIMM: o_imm = w_imm_i;
      OPC_STORE:                     o_imm = w_imm_s;
      OPC_BRANCH:                    o_imm = w_imm_b;
      OPC_LUI, OPC_AUIPC:            o_imm = w_imm_u;
      OPC_JAL:                       o_imm = w_imm_j;
      default:                       o_imm = DATA_ZERO;
    endcase
  end

endmodule

// File: rtl/idu_stage.sv
// RV32I decode stage: combinational control/operand decode of one instruction,
// with a single registered handshake valid.
import cfg::*;

module idu_stage (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_sys_ready,
  output logic                  o_sys_valid,
  input  logic [INST_WIDTH-1:0] i_ram_inst,
  output logic [3:0]            o_idu_ctr_alu_type,
  output logic [1:0]            o_idu_ctr_alu_rs1,
  output logic [1:0]            o_idu_ctr_alu_rs2,
  output logic [3:0]            o_idu_ctr_jmp_type,
  output logic                  o_idu_ctr_ram_wr_en,
  output logic [2:0]            o_idu_ctr_ram_byt,
  output logic                  o_idu_ctr_reg_wr_en,
  output logic [1:0]            o_idu_ctr_reg_wr_src,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs2_data,
  output logic [4:0]            o_idu_gpr_rs1_id,
  output logic [4:0]            o_idu_gpr_rs2_id,
  output logic [4:0]            o_idu_gpr_rd_id,
  input  logic [DATA_WIDTH-1:0] i_ifu_pc,
  output logic [DATA_WIDTH-1:0] o_idu_rs1_data,
  output logic [DATA_WIDTH-1:0] o_idu_rs2_data,
  output logic [DATA_WIDTH-1:0] o_idu_jmp_or_reg_data,
  output logic                  o_idu_end_flag
);

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic                  w_funct7_b5;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_nop;
  alu_type_e             w_alu_type;
  alu_a_e                w_alu_a;
  alu_b_e                w_alu_b;
  jmp_type_e             w_jmp_type;
  logic                  w_ram_wr_en;
  logic [2:0]            w_ram_byt;
  logic                  w_reg_wr_en;
  wr_src_e               w_wr_src;
  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;
  logic [DATA_WIDTH-1:0] w_jmp_data;
  logic                  r_sys_valid;

  assign w_opcode    = i_ram_inst[6:0];
  assign w_funct3    = i_ram_inst[14:12];
  assign w_funct7_b5 = i_ram_inst[30];

  idu_imm_gen u_imm_gen (
    .i_inst (i_ram_inst),
    .o_imm  (w_imm)
  );

  // Control decode; anything not recognised below stays a NOP with all writes off.
  always_comb begin
    w_nop       = 1'b1;
    w_alu_type  = ALU_ADD;
    w_alu_a     = ALU_A_ZERO;
    w_alu_b     = ALU_B_IMM;
    w_jmp_type  = JMP_NONE;
    w_ram_wr_en = 1'b0;
    w_ram_byt   = 3'b000;
    w_reg_wr_en = 1'b0;
    w_wr_src    = WR_SRC_ALU;
    case (w_opcode)
      OPC_LUI: begin
        w_nop       = 1'b0;
        w_reg_wr_en = 1'b1;
      end
      OPC_AUIPC: begin
        w_nop       = 1'b0;
        w_alu_a     = ALU_A_PC;
        w_reg_wr_en = 1'b1;
      end
      OPC_JAL: begin
        w_nop       = 1'b0;
        w_jmp_type  = JMP_JAL;
        w_alu_a     = ALU_A_PC;
        w_alu_b     = ALU_B_FOUR;
        w_reg_wr_en = 1'b1;
        w_wr_src    = WR_SRC_PC4;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_nop       = 1'b0;
          w_jmp_type  = JMP_JALR;
          w_alu_a     = ALU_A_PC;
          w_alu_b     = ALU_B_FOUR;
          w_reg_wr_en = 1'b1;
          w_wr_src    = WR_SRC_PC4;
        end else begin
          w_nop = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (w_funct3)
          3'b000:  begin w_jmp_type = JMP_BEQ;  w_alu_type = ALU_EQ;  end
          3'b001:  begin w_jmp_type = JMP_BNE;  w_alu_type = ALU_NE;  end
          3'b100:  begin w_jmp_type = JMP_BLT;  w_alu_type = ALU_LT;  end
          3'b101:  begin w_jmp_type = JMP_BGE;  w_alu_type = ALU_GE;  end
          3'b110:  begin w_jmp_type = JMP_BLTU; w_alu_type = ALU_LTU; end
          3'b111:  begin w_jmp_type = JMP_BGEU; w_alu_type = ALU_GEU; end
          default: begin w_jmp_type = JMP_NONE; w_alu_type = ALU_ADD; end
        endcase
        if (w_jmp_type != JMP_NONE) begin
          w_nop   = 1'b0;
          w_alu_a = ALU_A_RS1;
          w_alu_b = ALU_B_RS2;
        end else begin
          w_nop = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (is_load_funct3(w_funct3)) begin
          w_nop       = 1'b0;
          w_alu_a     = ALU_A_RS1;
          w_ram_byt   = w_funct3;
          w_reg_wr_en = 1'b1;
          w_wr_src    = WR_SRC_MEM;
        end else begin
          w_nop = 1'b1;
        end
      end
      OPC_STORE: begin
        if (w_funct3 < 3'b011) begin
          w_nop       = 1'b0;
          w_alu_a     = ALU_A_RS1;
          w_ram_wr_en = 1'b1;
          w_ram_byt   = w_funct3;
        end else begin
          w_nop = 1'b1;
        end
      end
      OPC_OPIMM, OPC_OP: begin
        w_nop       = 1'b0;
        w_alu_a     = ALU_A_RS1;
        w_alu_b     = (w_opcode == OPC_OP) ? ALU_B_RS2 : ALU_B_IMM;
        w_reg_wr_en = 1'b1;
        case (w_funct3)
          3'b000:  w_alu_type = ((w_opcode == OPC_OP) && w_funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_type = ALU_SLL;
          3'b010:  w_alu_type = ALU_SLT;
          3'b011:  w_alu_type = ALU_SLTU;
          3'b100:  w_alu_type = ALU_XOR;
          3'b101:  w_alu_type = w_funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_type = ALU_OR;
          3'b111:  w_alu_type = ALU_AND;
          default: w_alu_type = ALU_ADD;
        endcase
      end
      default: w_nop = 1'b1;
    endcase
  end

  // Operand and jump/store data resolution; a NOP drives all data to zero.
  always_comb begin
    w_rs1_data = DATA_ZERO;
    w_rs2_data = DATA_ZERO;
    w_jmp_data = DATA_ZERO;
    if (w_nop) begin
      w_rs1_data = DATA_ZERO;
    end else begin
      case (w_alu_a)
        ALU_A_RS1: w_rs1_data = i_gpr_rs1_data;
        ALU_A_PC:  w_rs1_data = i_ifu_pc;
        default:   w_rs1_data = DATA_ZERO;
      endcase
      case (w_alu_b)
        ALU_B_RS2:  w_rs2_data = i_gpr_rs2_data;
        ALU_B_IMM:  w_rs2_data = w_imm;
        ALU_B_FOUR: w_rs2_data = DATA_FOUR;
        default:    w_rs2_data = DATA_ZERO;
      endcase
      case (w_jmp_type)
        JMP_JAL:  w_jmp_data = i_ifu_pc + w_imm;
        JMP_JALR: w_jmp_data = (i_gpr_rs1_data + w_imm) & ~DATA_ZERO << 1;
        JMP_BEQ, JMP_BNE, JMP_BLT, JMP_BGE, JMP_BLTU, JMP_BGEU:
                  w_jmp_data = i_ifu_pc + w_imm;
        default:  w_jmp_data = w_ram_wr_en ? i_gpr_rs2_data : DATA_ZERO;
      endcase
    end
  end

  // Handshake valid follows downstream ready one edge later; cleared asynchronously by reset.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_sys_valid <= 1'b0;
    end else begin
      r_sys_valid <= i_sys_ready;
    end
  end

  assign o_sys_valid           = r_sys_valid;
  assign o_idu_ctr_alu_type    = w_alu_type;
  assign o_idu_ctr_alu_rs1     = w_alu_a;
  assign o_idu_ctr_alu_rs2     = w_alu_b;
  assign o_idu_ctr_jmp_type    = w_jmp_type;
  assign o_idu_ctr_ram_wr_en   = w_ram_wr_en;
  assign o_idu_ctr_ram_byt     = w_ram_byt;
  assign o_idu_ctr_reg_wr_en   = w_reg_wr_en;
  assign o_idu_ctr_reg_wr_src  = w_wr_src;
  assign o_idu_gpr_rs1_id      = i_ram_inst[19:15];
  assign o_idu_gpr_rs2_id      = i_ram_inst[24:20];
  assign o_idu_gpr_rd_id       = i_ram_inst[11:7];
  assign o_idu_rs1_data        = w_rs1_data;
  assign o_idu_rs2_data        = w_rs2_data;
  assign o_idu_jmp_or_reg_data = w_jmp_data;
  assign o_idu_end_flag        = (i_ram_inst == INST_EBREAK) & r_sys_valid;

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: directed test-plan steps followed by
// randomized instructions compared against a behavioural decode model.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [31:0] inst, rs1, rs2, pc;
  logic        o_valid, o_ram_wr, o_reg_wr, o_end;
  logic [3:0]  o_alu, o_jmp;
  logic [1:0]  o_a, o_b, o_src;
  logic [2:0]  o_byt;
  logic [4:0]  o_rs1_id, o_rs2_id, o_rd_id;
  logic [31:0] o_ad, o_bd, o_jd;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_valid;

  always #5 clk = ~clk;

  idu_stage dut (
    .i_sys_clk             (clk),
    .i_sys_rst_n           (rst_n),
    .i_sys_ready           (ready),
    .o_sys_valid           (o_valid),
    .i_ram_inst            (inst),
    .o_idu_ctr_alu_type    (o_alu),
    .o_idu_ctr_alu_rs1     (o_a),
    .o_idu_ctr_alu_rs2     (o_b),
    .o_idu_ctr_jmp_type    (o_jmp),
    .o_idu_ctr_ram_wr_en   (o_ram_wr),
    .o_idu_ctr_ram_byt     (o_byt),
    .o_idu_ctr_reg_wr_en   (o_reg_wr),
    .o_idu_ctr_reg_wr_src  (o_src),
    .i_gpr_rs1_data        (rs1),
    .i_gpr_rs2_data        (rs2),
    .o_idu_gpr_rs1_id      (o_rs1_id),
    .o_idu_gpr_rs2_id      (o_rs2_id),
    .o_idu_gpr_rd_id       (o_rd_id),
    .i_ifu_pc              (pc),
    .o_idu_rs1_data        (o_ad),
    .o_idu_rs2_data        (o_bd),
    .o_idu_jmp_or_reg_data (o_jd),
    .o_idu_end_flag        (o_end)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [3:0]  jmp;
    logic        ram_wr;
    logic [2:0]  byt;
    logic        reg_wr;
    logic [1:0]  src;
    logic [31:0] ad;
    logic [31:0] bd;
    logic [31:0] jd;
  } exp_t;

  // funct3-indexed lookup tables (ALU codes: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 EQ10 NE11 LT12 GE13 LTU14 GEU15)
  localparam logic [3:0] BR_ALU [0:7] = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd12, 4'd13, 4'd14, 4'd15};
  localparam logic [3:0] BR_JMP [0:7] = '{4'd3, 4'd4, 4'd0, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8};
  localparam logic [3:0] AR_ALU [0:7] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  function automatic exp_t model(input logic [31:0] in, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] p);
    exp_t e;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  op;
    logic [2:0]  f3;
    imm_i = 32'($signed(in) >>> 20);
    imm_s = (32'($signed(in) >>> 25) << 5) | 32'(in[11:7]);
    imm_b = (32'($signed(in) >>> 31) << 12) | (32'(in[7]) << 11) |
            (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
    imm_u = in & 32'hFFFF_F000;
    imm_j = (32'($signed(in) >>> 31) << 20) | (32'(in[19:12]) << 12) |
            (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
    op = in[6:0];
    f3 = in[14:12];
    e = '0;
    e.a = 2'd2;  // ZERO
    e.b = 2'd1;  // IMM
    case (op)
      7'h37: begin e.reg_wr = 1'b1; e.bd = imm_u; end
      7'h17: begin e.reg_wr = 1'b1; e.a = 2'd1; e.ad = p; e.bd = imm_u; end
      7'h6f: begin
        e.jmp = 4'd1; e.reg_wr = 1'b1; e.src = 2'd2;
        e.a = 2'd1; e.b = 2'd2; e.ad = p; e.bd = 32'd4; e.jd = p + imm_j;
      end
      7'h67: if (f3 == 3'd0) begin
        e.jmp = 4'd2; e.reg_wr = 1'b1; e.src = 2'd2;
        e.a = 2'd1; e.b = 2'd2; e.ad = p; e.bd = 32'd4;
        e.jd = (r1 + imm_i) & 32'hFFFF_FFFE;
      end
      7'h63: if (BR_JMP[f3] != 4'd0) begin
        e.jmp = BR_JMP[f3]; e.alu = BR_ALU[f3];
        e.a = 2'd0; e.b = 2'd0; e.ad = r1; e.bd = r2; e.jd = p + imm_b;
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        e.a = 2'd0; e.ad = r1; e.bd = imm_i; e.byt = f3;
        e.reg_wr = 1'b1; e.src = 2'd1;
      end
      7'h23: if (f3 <= 3'd2) begin
        e.a = 2'd0; e.ad = r1; e.bd = imm_s; e.byt = f3;
        e.ram_wr = 1'b1; e.jd = r2;
      end
      7'h13, 7'h33: begin
        e.reg_wr = 1'b1; e.a = 2'd0; e.ad = r1;
        e.alu = AR_ALU[f3];
        if (op == 7'h33 && f3 == 3'd0 && in[30]) e.alu = 4'd1;
        if (f3 == 3'd5 && in[30]) e.alu = 4'd7;
        if (op == 7'h33) begin e.b = 2'd0; e.bd = r2; end
        else begin e.bd = imm_i; end
      end
      default: e.a = 2'd2;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    exp_t e;
    e = model(inst, rs1, rs2, pc);
    chk({tag, ".alu"},    32'(o_alu),    32'(e.alu));
    chk({tag, ".a_sel"},  32'(o_a),      32'(e.a));
    chk({tag, ".b_sel"},  32'(o_b),      32'(e.b));
    chk({tag, ".jmp"},    32'(o_jmp),    32'(e.jmp));
    chk({tag, ".ram_wr"}, 32'(o_ram_wr), 32'(e.ram_wr));
    chk({tag, ".byt"},    32'(o_byt),    32'(e.byt));
    chk({tag, ".reg_wr"}, 32'(o_reg_wr), 32'(e.reg_wr));
    chk({tag, ".src"},    32'(o_src),    32'(e.src));
    chk({tag, ".a_dat"},  o_ad,          e.ad);
    chk({tag, ".b_dat"},  o_bd,          e.bd);
    chk({tag, ".j_dat"},  o_jd,          e.jd);
    chk({tag, ".rs1id"},  32'(o_rs1_id), 32'(inst >> 15) & 32'h1F);
    chk({tag, ".rs2id"},  32'(o_rs2_id), 32'(inst >> 20) & 32'h1F);
    chk({tag, ".rdid"},   32'(o_rd_id),  32'(inst >> 7) & 32'h1F);
    chk({tag, ".valid"},  32'(o_valid),  32'(exp_valid));
    chk({tag, ".end"},    32'(o_end),    32'(exp_valid && inst == 32'h0010_0073));
  endtask

  task automatic step(input string tag, input logic [31:0] i);
    inst = i;
    #1;
    check_all(tag);
  endtask

  initial begin
    int cls;
    rst_n = 1'b0; ready = 1'b1; exp_valid = 1'b0;
    inst = 32'h0010_0073; pc = 32'h8000_0000; rs1 = 32'd1; rs2 = 32'd2;

    // reset: valid and end flag held low even with ebreak and ready present
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.end",   32'(o_end),   32'd0);

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); exp_valid = 1'b1; #1;
    chk("valid_after_rst", 32'(o_valid), 32'd1);

    step("lui", 32'h0000_a0b7);
    chk("lui.A", o_ad, 32'd0);          chk("lui.B", o_bd, 32'h0000_A000);
    chk("lui.alu", 32'(o_alu), 32'd0);  chk("lui.rd", 32'(o_rd_id), 32'd1);
    chk("lui.wr", 32'(o_reg_wr), 32'd1); chk("lui.src", 32'(o_src), 32'd0);
    step("auipc", 32'h0000_a097);
    chk("auipc.A", o_ad, 32'h8000_0000); chk("auipc.B", o_bd, 32'h0000_A000);
    step("jal", 32'h00a0_00ef);
    chk("jal.jmp", 32'(o_jmp), 32'd1);  chk("jal.jd", o_jd, 32'h8000_000A);
    chk("jal.src", 32'(o_src), 32'd2);
    step("jalr", 32'h00a1_00e7);
    chk("jalr.jd", o_jd, 32'h0000_000A); chk("jalr.rs1id", 32'(o_rs1_id), 32'd2);
    step("beq", 32'h0020_8563);
    chk("beq.jmp", 32'(o_jmp), 32'd3);  chk("beq.alu", 32'(o_alu), 32'd10);
    chk("beq.A", o_ad, 32'd1);          chk("beq.B", o_bd, 32'd2);
    chk("beq.jd", o_jd, 32'h8000_000A); chk("beq.wr", 32'(o_reg_wr | o_ram_wr), 32'd0);
    step("lb", 32'h00a1_0083);
    chk("lb.B", o_bd, 32'd10); chk("lb.byt", 32'(o_byt), 32'd0); chk("lb.src", 32'(o_src), 32'd1);
    step("sb", 32'h0011_0023);
    chk("sb.ram_wr", 32'(o_ram_wr), 32'd1); chk("sb.B", o_bd, 32'd0);
    chk("sb.jd", o_jd, 32'd2);              chk("sb.reg_wr", 32'(o_reg_wr), 32'd0);
    step("addi", 32'h00a1_0093);
    chk("addi.A", o_ad, 32'd1); chk("addi.B", o_bd, 32'd10);
    step("add", 32'h0031_00b3);
    chk("add.rs1id", 32'(o_rs1_id), 32'd2); chk("add.rs2id", 32'(o_rs2_id), 32'd3);
    chk("add.rd", 32'(o_rd_id), 32'd1);     chk("add.B", o_bd, 32'd2);
    step("sub", 32'h4031_00b3);
    chk("sub.alu", 32'(o_alu), 32'd1);
    step("fence", 32'h0000_000f);
    chk("fence.wr", 32'({o_reg_wr, o_ram_wr, o_jmp}), 32'd0);
    step("ecall", 32'h0000_0073);
    chk("ecall.wr", 32'({o_reg_wr, o_ram_wr, o_jmp}), 32'd0);
    step("ebreak", 32'h0010_0073);
    chk("ebreak.end", 32'(o_end), 32'd1);

    // ready low: valid drops on the next edge and end flag follows
    @(negedge clk); ready = 1'b0;
    @(posedge clk); exp_valid = 1'b0; #1;
    chk("ready0.valid", 32'(o_valid), 32'd0);
    chk("ready0.end",   32'(o_end),   32'd0);
    @(negedge clk); ready = 1'b1;
    @(posedge clk); exp_valid = 1'b1; #1;
    chk("ready1.end", 32'(o_end), 32'd1);

    // asynchronous reset between edges; decode keeps working
    @(negedge clk); inst = 32'h00a1_0093; #2;
    rst_n = 1'b0; #1;
    exp_valid = 1'b0;
    check_all("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); exp_valid = 1'b1; #1;

    // randomized instructions against the model
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      cls  = int'($urandom_range(0, 12));
      inst = $urandom;
      case (cls)
        0:  inst[6:0] = 7'h37;
        1:  inst[6:0] = 7'h17;
        2:  inst[6:0] = 7'h6f;
        3:  inst[6:0] = 7'h67;
        4:  inst[6:0] = 7'h63;
        5:  inst[6:0] = 7'h03;
        6:  inst[6:0] = 7'h23;
        7:  begin
          inst[6:0] = 7'h13;
          if (inst[13:12] == 2'b01) inst[31:25] = {1'b0, inst[30], 5'd0};
        end
        8:  begin inst[6:0] = 7'h33; inst[31:25] = {1'b0, inst[30], 5'd0}; end
        9:  inst[6:0] = 7'h0f;
        10: inst[6:0] = 7'h73;
        11: inst = 32'h0010_0073;
        default: inst[1:0] = inst[1:0];
      endcase
      rs1   = $urandom;
      rs2   = $urandom;
      pc    = $urandom & 32'hFFFF_FFFC;
      ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      exp_valid = ready;
      #1;
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
